// File: rtl/emmc_blk_arb.sv
// emmc_blk_arb: two-requester round-robin arbiter/sequencer issuing one single-block
// command per grant to the eMMC block state machine. Optional watchdog: EMMC_ARB_TIMEOUT_EN.
module emmc_blk_arb #(
  parameter int unsigned BLK_BYTES   = 512,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] req_we_i,
  input  logic [7:0] wdat0_i,
  input  logic [7:0] wdat1_i,
  output logic [1:0] gnt_o,
  output logic [1:0] wrd_o,
  output logic [7:0] rdat_o,
  output logic [1:0] rvld_o,
  output logic [1:0] done_o,
  output logic [1:0] err_o,
  output logic       sm_we_o,
  output logic       sm_start_o,
  output logic [7:0] sm_dat_o,
  input  logic [7:0] sm_dat_i,
  input  logic       sm_dvalid_i,
  input  logic       sm_ready_i
);

  localparam int unsigned CW = $clog2(BLK_BYTES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BLK_BYTES);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, XFER, DONE
`ifdef EMMC_ARB_TIMEOUT_EN
    , DRAIN
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          start_q, start_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          win;
  logic [1:0]    owner_oh;

`ifdef EMMC_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog_q, wdog_d;
`endif

  // Priority goes to the requester after the last served one.
  assign win      = last_q ? ~req_i[0] : req_i[1];
  assign owner_oh = 2'b01 << owner_q;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    start_d = 1'b0;
    done_d  = 2'b00;
    err_d   = 2'b00;
`ifdef EMMC_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sm_ready_i && (req_i != 2'b00)) begin
          owner_d = win;
          we_d    = req_we_i[win];
          gnt_d   = 2'b01 << win;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
`ifdef EMMC_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!sm_ready_i) state_d = XFER;
      end
      XFER: begin
        if (sm_dvalid_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (sm_ready_i) begin
          state_d = DONE;
          if (cnt_d == CNT_FULL) done_d = owner_oh;
          else                   err_d  = owner_oh;
        end
      end
      DONE: begin
        last_d  = owner_q;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
`ifdef EMMC_ARB_TIMEOUT_EN
      DRAIN: begin
        if (sm_ready_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef EMMC_ARB_TIMEOUT_EN
    // Watchdog overrides a normal XFER completion that lands on the same cycle.
    if ((state_q == WAIT_ACK) || (state_q == XFER)) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_d == WW'(TIMEOUT_CYC)) begin
        state_d = DRAIN;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = owner_oh;
      end
    end
`endif
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      start_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
`ifdef EMMC_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef EMMC_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign sm_start_o = start_q;
  assign sm_we_o    = we_q;

  // Byte steering is qualified by the registered grant, so it is zero outside a transfer.
  assign sm_dat_o = gnt_q[1] ? wdat1_i : (gnt_q[0] ? wdat0_i : 8'h00);
  assign wrd_o    = gnt_q & {2{sm_dvalid_i &  we_q}};
  assign rvld_o   = gnt_q & {2{sm_dvalid_i & ~we_q}};
  assign rdat_o   = sm_dat_i;

endmodule

// File: tb/tb_emmc_blk_arb.sv
// tb_emmc_blk_arb: directed bench for emmc_blk_arb with a simple eMMC state machine model.
// Inputs change 1 time unit after the rising edge; outputs are counted on the falling edge.
module tb_emmc_blk_arb;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic [1:0] req_i, req_we_i;
  logic [7:0] wdat0_i, wdat1_i;
  logic [1:0] gnt_o, wrd_o, rvld_o, done_o, err_o;
  logic [7:0] rdat_o, sm_dat_o, sm_dat_i;
  logic       sm_we_o, sm_start_o, sm_dvalid_i, sm_ready_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_grants = 0;

  emmc_blk_arb #(.BLK_BYTES(512), .TIMEOUT_CYC(1000)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .req_i(req_i), .req_we_i(req_we_i),
    .wdat0_i(wdat0_i), .wdat1_i(wdat1_i), .gnt_o(gnt_o), .wrd_o(wrd_o),
    .rdat_o(rdat_o), .rvld_o(rvld_o), .done_o(done_o), .err_o(err_o),
    .sm_we_o(sm_we_o), .sm_start_o(sm_start_o), .sm_dat_o(sm_dat_o),
    .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i), .sm_ready_i(sm_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters; read bytes must follow 0x00..0xFF from each start.
  int wrd_n[2], rvld_n[2], done_n[2], err_n[2];
  int start_n = 0, rdat_bad = 0, xidx = 0;
  initial for (int k = 0; k < 2; k++) begin
    wrd_n[k] = 0; rvld_n[k] = 0; done_n[k] = 0; err_n[k] = 0;
  end

  always @(negedge clk_i) begin
    if (sm_start_o) begin
      start_n++;
      xidx = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (wrd_o[k])  wrd_n[k]++;
      if (done_o[k]) done_n[k]++;
      if (err_o[k])  err_n[k]++;
      if (rvld_o[k]) begin
        if (rdat_o != 8'(xidx)) rdat_bad++;
        rvld_n[k]++;
        xidx++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Returns in the ISSUE cycle (sm_start_o high), or flags a timeout.
  task automatic wait_start(input string tag);
    int t = 0;
    while (!sm_start_o && t < 20) begin
      step();
      t++;
    end
    check({tag, "_start_seen"}, 32'(sm_start_o), 32'd1);
    if (sm_start_o) n_grants++;
  endtask

  // Called in the ISSUE cycle; returns in the DONE cycle.
  task automatic xfer(input int nbytes);
    step();
    sm_ready_i = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      step();
      sm_dvalid_i = 1'b1;
      sm_dat_i    = 8'(i);
    end
    step();
    sm_dvalid_i = 1'b0;
    sm_ready_i  = 1'b1;
    step();
  endtask

  int b_wrd0, b_rvld0, b_rvld1, b_done0, b_done1, b_err0, b_err1;
  task automatic snap();
    b_wrd0 = wrd_n[0]; b_rvld0 = rvld_n[0]; b_rvld1 = rvld_n[1];
    b_done0 = done_n[0]; b_done1 = done_n[1]; b_err0 = err_n[0]; b_err1 = err_n[1];
  endtask

  initial begin
    arst_i = 1'b1; req_i = 2'b00; req_we_i = 2'b00;
    wdat0_i = 8'hA5; wdat1_i = 8'h3C; sm_dat_i = 8'h5A;
    sm_dvalid_i = 1'b0; sm_ready_i = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt_o),      32'h0);
    check("rst_start", 32'(sm_start_o), 32'h0);
    check("rst_we",    32'(sm_we_o),    32'h0);
    check("rst_pulse", 32'({done_o, err_o, wrd_o, rvld_o}), 32'h0);
    check("rst_smdat", 32'(sm_dat_o),   32'h0);
    check("rst_rdat",  32'(rdat_o),     32'h5A);
    step(); step();
    arst_i = 1'b0;

    // Single write on req 0, held off by sm_ready_i=0 first.
    snap();
    req_i = 2'b01; req_we_i = 2'b01;
    repeat (5) step();
    check("noready_gnt",   32'(gnt_o), 32'h0);
    check("noready_start", 32'(start_n), 32'd0);
    sm_ready_i = 1'b1;
    step();
    check("wr_gnt",   32'(gnt_o),      32'h1);
    check("wr_start", 32'(sm_start_o), 32'h1);
    check("wr_we",    32'(sm_we_o),    32'h1);
    check("wr_smdat", 32'(sm_dat_o),   32'hA5);
    n_grants++;
    xfer(512);
    check("wr_done_pulse", 32'(done_o), 32'h1);
    check("wr_gnt_in_done", 32'(gnt_o), 32'h1);
    req_i = 2'b00;
    step();
    check("wr_gnt_after", 32'(gnt_o), 32'h0);
    check("wr_wrd0_cnt",  32'(wrd_n[0] - b_wrd0), 32'd512);
    check("wr_wrd1_cnt",  32'(wrd_n[1]), 32'd0);
    check("wr_done_cnt",  32'(done_n[0] - b_done0), 32'd1);
    check("wr_err_cnt",   32'(err_n[0] + err_n[1]), 32'd0);

    // Short read on req 1: only 100 bytes.
    snap();
    req_i = 2'b10; req_we_i = 2'b00;
    wait_start("short");
    check("short_gnt", 32'(gnt_o),   32'h2);
    check("short_we",  32'(sm_we_o), 32'h0);
    xfer(100);
    check("short_err_pulse",  32'(err_o),  32'h2);
    check("short_done_pulse", 32'(done_o), 32'h0);
    req_i = 2'b00;
    step(); step();
    check("short_gnt_idle", 32'(gnt_o), 32'h0);
    check("short_err_cnt",  32'(err_n[1] - b_err1), 32'd1);
    check("short_done_cnt", 32'(done_n[1] - b_done1), 32'd0);
    check("short_rvld_cnt", 32'(rvld_n[1] - b_rvld1), 32'd100);

    // Both request reads; 0 wins first, then 1.
    snap();
    req_i = 2'b11; req_we_i = 2'b00;
    wait_start("both0");
    check("both_gnt0", 32'(gnt_o), 32'h1);
    xfer(512);
    check("both_done0", 32'(done_o), 32'h1);
    req_i[0] = 1'b0;
    wait_start("both1");
    check("both_gnt1", 32'(gnt_o), 32'h2);
    xfer(512);
    check("both_done1", 32'(done_o), 32'h2);
    req_i = 2'b00;
    step();
    check("both_rvld0", 32'(rvld_n[0] - b_rvld0), 32'd512);
    check("both_rvld1", 32'(rvld_n[1] - b_rvld1), 32'd512);
    check("both_rdat",  32'(rdat_bad), 32'd0);
    check("both_done_cnt", 32'((done_n[0] - b_done0) + (done_n[1] - b_done1)), 32'd2);

    // Reset mid-transfer after 200 bytes on req 1, then a clean retry.
    snap();
    req_i = 2'b10;
    wait_start("abort");
    step();
    sm_ready_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      sm_dvalid_i = 1'b1;
      sm_dat_i    = 8'(i);
    end
    step();
    arst_i = 1'b1;
    #1;
    check("abort_gnt",  32'(gnt_o),  32'h0);
    check("abort_rvld", 32'(rvld_o), 32'h0);
    sm_dvalid_i = 1'b0;
    step();
    arst_i = 1'b0; sm_ready_i = 1'b1;
    check("abort_no_pulse", 32'((done_n[1] - b_done1) + (err_n[1] - b_err1)), 32'd0);
    wait_start("retry");
    check("retry_gnt", 32'(gnt_o), 32'h2);
    xfer(512);
    check("retry_done", 32'(done_o), 32'h2);
    req_i = 2'b00;
    step();
    check("retry_rdat", 32'(rdat_bad), 32'd0);

`ifdef EMMC_ARB_TIMEOUT_EN
    // The model never acknowledges: watchdog fires 1000 cycles after WAIT_ACK entry.
    begin
      int cyc = 0;
      snap();
      req_i = 2'b01;
      wait_start("wdog");
      step();
      while (!err_o[0] && cyc < 1100) begin
        step();
        cyc++;
      end
      check("wdog_cycles", 32'(cyc), 32'd1000);
      check("wdog_gnt", 32'(gnt_o), 32'h0);
      wait_start("wdog_next");
      xfer(512);
      check("wdog_next_done", 32'(done_o), 32'h1);
      req_i = 2'b00;
      step();
    end
`endif

    check("start_per_grant", 32'(start_n), 32'(n_grants));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/emmc_blk_arb.md
# emmc_blk_arb

Two-requester round-robin arbiter and sequencer in front of the eMMC block state machine's byte interface (`we`/`start`/`dat`/`dvalid`/`ready`). It shares the card between two block-level clients (e.g. a logger writer and a readback engine), issues exactly one single-block command per grant, steers write/read bytes to the owner and reports completion or error per requester.

## Interface
Parameters:
- BLK_BYTES, 512, bytes per block transfer; must match the state machine's block size.
- TIMEOUT_CYC, 2**20, watchdog limit in clk_i cycles (only with EMMC_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- req_i  in  [1:0]  per-requester request level; held until done_o/err_o.
- req_we_i  in  [1:0]  per-requester direction (1 = write, 0 = read); sampled at grant.
- wdat0_i, wdat1_i  in  [7:0]  write byte from requester 0 / 1.
- gnt_o  out  [1:0]  one-hot grant, registered.
- wrd_o  out  [1:0]  write byte consumed strobe to the owner.
- rdat_o  out  [7:0]  read byte, shared by both requesters.
- rvld_o  out  [1:0]  read byte valid strobe to the owner.
- done_o  out  [1:0]  one-cycle completion pulse, registered.
- err_o  out  [1:0]  one-cycle error pulse, registered.
- sm_we_o  out  1  direction to the state machine, registered.
- sm_start_o  out  1  one-cycle start pulse, registered.
- sm_dat_o  out  [7:0]  write byte to the state machine.
- sm_dat_i  in  [7:0]  read byte from the state machine.
- sm_dvalid_i  in  1  byte strobe (write consumed or read valid).
- sm_ready_i  in  1  state machine idle and able to accept a command.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK, XFER, DONE, DRAIN.
- IDLE: when sm_ready_i=1 and req_i!=0, pick the winner round-robin: priority goes to the requester after the last served one. After reset, requester 0 has priority. Latch owner and req_we_i[owner]. Go to ISSUE.
- ISSUE (1 cycle): gnt_o[owner]=1, sm_start_o=1, sm_we_o=latched we, byte counter cleared. Go to WAIT_ACK.
- WAIT_ACK: wait for sm_ready_i=0, then go to XFER.
- XFER: each sm_dvalid_i increments the byte counter. The counter is $clog2(BLK_BYTES+1) bits wide and saturates at all-ones. When sm_ready_i=1, go to DONE.
- DONE (1 cycle):
  - done_o[owner]=1 if count==BLK_BYTES; otherwise err_o[owner]=1.
  - Last-served pointer is updated to owner.
  - gnt_o stays high during DONE and is 0 from the next cycle.
  - Go to IDLE.
- Datapath (combinational, owner-qualified, zero when no grant):
  - sm_dat_o = owner's wdat.
  - wrd_o[owner] = sm_dvalid_i & we.
  - rvld_o[owner] = sm_dvalid_i & ~we.
  - rdat_o = sm_dat_i.
- The requester must drop req_i the cycle after sampling done_o/err_o. If req_i is still high in IDLE, it is treated as a new request.
- If req_i drops mid-transaction, it is ignored; the block transfer always completes.
- If req_we_i changes after the grant, it is ignored.
- Simultaneous requests: exactly one grant; the loser keeps waiting and is served next.

## Timing
- Reset values: gnt_o, wrd_o, rvld_o, done_o, err_o, sm_we_o, sm_start_o = 0; sm_dat_o, rdat_o follow the datapath rules (0 with no grant, rdat_o = sm_dat_i). FSM = IDLE; last-served = 1 (so requester 0 wins first). Counters = 0.
- Request to start: req_i seen in IDLE at cycle N; gnt_o and sm_start_o are high at N+1.
- sm_start_o is high for exactly 1 cycle per grant.
- Completion: sm_ready_i rising seen at cycle M; done_o/err_o pulse at M+1; gnt_o is 0 at M+2.
- Minimum gap between two grants: 1 IDLE cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No pulse is emitted for the aborted transfer.

## Configuration
- EMMC_ARB_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_ACK and XFER.
  - When it reaches TIMEOUT_CYC, err_o[owner] pulses, gnt_o drops and the datapath is gated off. The FSM goes to DRAIN.
  - DRAIN waits for sm_ready_i=1, then goes to IDLE.
- Undefined: no watchdog and no DRAIN state; the block waits indefinitely for sm_ready_i.

## Test plan
- Single write on req 0, model consumes 512 bytes → wrd_o[0] pulses 512 times; done_o[0] pulses once; sm_we_o=1; err_o=0.
- req_i=2'b11 held through two transactions (req_we_i=2'b00) → grants are 0 then 1 (2'b01, 2'b10); each gets done_o; rdat_o matches model bytes 0x00..0xFF repeated.
- Read where the model returns only 100 dvalid strobes → err_o[1] pulses, done_o stays 0, arbiter returns to IDLE.
- arst_i asserted mid-XFER after 200 bytes → gnt_o=0 within the same cycle; after release, a new req 1 is granted and completes with done_o[1].
- With EMMC_ARB_TIMEOUT_EN and TIMEOUT_CYC=1000, the model never drops sm_ready_i → err_o[0] pulses 1000 cycles after WAIT_ACK entry; DRAIN then IDLE; the next grant succeeds.
- sm_ready_i=0 while req_i[0]=1 → no grant and no sm_start_o until sm_ready_i=1.
